alu_cmd_issuer: RTL and testbench

Command front-end for `sequential_alu`: accepts operand/operation commands over a valid/ready channel, buffers them in a DEPTH-entry FIFO, and issues at most one command per cycle to the ALU. It tracks the ALU's one-cycle register latency and captures each result into a 2-entry result queue. The queue is presented downstream over a valid/ready channel, so ALU results are never lost under backpressure. It sits directly upstream of `sequential_alu` and drives its `op1`, `op2` and `operation` inputs.

---
 rtl/alu_cmd_issuer.sv | 126 ++++++++++++
 tb/tb_alu_cmd_issuer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_issuer.sv
`default_nettype none
// ============================================================================
// alu_cmd_issuer : command FIFO, issue control and 2-entry result queue that
//                  front-end sequential_alu (one-cycle registered result).
// Rev 1.0 - initial release
// ============================================================================
module alu_cmd_issuer #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_op1,
  input  logic [WIDTH-1:0]           in_op2,
  input  logic [1:0]                 in_operation,
  output logic [WIDTH-1:0]           alu_op1,
  output logic [WIDTH-1:0]           alu_op2,
  output logic [1:0]                 alu_operation,
  input  logic [WIDTH-1:0]           alu_result,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_result,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int c_AW   = $clog2(DEPTH);
  localparam int c_CW   = $clog2(DEPTH + 1);
  localparam int c_CMDW = 2 * WIDTH + 2;
  localparam logic [c_AW-1:0] c_PTR_ONE  = c_AW'(1);
  localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);
  localparam logic [c_CW-1:0] c_CNT_FULL = c_CW'(DEPTH);

  logic [c_CMDW-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]   r_wr_ptr;
  logic [c_AW-1:0]   r_rd_ptr;
  logic [c_CW-1:0]   r_count;
  logic              r_pending;
  logic [WIDTH-1:0]  r_rq_mem [2];
  logic              r_rq_wr;
  logic              r_rq_rd;
  logic [1:0]        r_rq_count;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_issue;
  logic              w_rq_pop;
  logic [2:0]        w_rq_occ;
  logic [c_CMDW-1:0] w_head;

  assign w_full   = (r_count == c_CNT_FULL);
  assign w_empty  = (r_count == '0);
  assign in_ready = !w_full;
  assign w_push   = in_valid && !w_full;
  assign count    = r_count;

  assign out_valid  = (r_rq_count != 2'd0);
  assign w_rq_pop   = out_valid && out_ready;
  assign out_result = out_valid ? r_rq_mem[r_rq_rd] : '0;

  // Slots the queue will hold after this edge if nothing new is issued;
  // issuing is only safe when a slot remains for the in-flight result.
  assign w_rq_occ = {1'b0, r_rq_count} + {2'b00, r_pending} - {2'b00, w_rq_pop};
  assign w_issue  = !w_empty && (w_rq_occ < 3'd2);
  assign w_head   = r_mem[r_rd_ptr];

  always_comb begin
    alu_op1       = '0;
    alu_op2       = '0;
    alu_operation = '0;
    if (w_issue) begin
      {alu_op1, alu_op2, alu_operation} = w_head;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {in_op1, in_op2, in_operation};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_pending <= 1'b0;
    end else begin
      if (w_push)  r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_issue) r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      case ({w_push, w_issue})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
      r_pending <= w_issue;
    end
  end

  // The ALU result for the command issued last cycle is valid exactly now.
  always_ff @(posedge clk) begin
    if (r_pending) begin
      r_rq_mem[r_rq_wr] <= alu_result;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rq_wr    <= 1'b0;
      r_rq_rd    <= 1'b0;
      r_rq_count <= 2'd0;
    end else begin
      if (r_pending) r_rq_wr <= ~r_rq_wr;
      if (w_rq_pop)  r_rq_rd <= ~r_rq_rd;
      case ({r_pending, w_rq_pop})
        2'b10:   r_rq_count <= r_rq_count + 2'd1;
        2'b01:   r_rq_count <= r_rq_count - 2'd1;
        default: r_rq_count <= r_rq_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_issuer.sv
`default_nettype none
// ============================================================================
// tb_alu_cmd_issuer : directed bench with result scoreboard and an ALU model.
// Rev 1.0 - initial release
// ============================================================================
module tb_alu_cmd_issuer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_op1;
  logic [15:0] in_op2;
  logic [1:0]  in_operation;
  logic [15:0] alu_op1;
  logic [15:0] alu_op2;
  logic [1:0]  alu_operation;
  logic [15:0] alu_result;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [2:0]  count;

  int          total = 0;
  int          bad   = 0;
  logic [15:0] sb[$];
  logic [15:0] cur_exp;

  always #5 clk = ~clk;

  alu_cmd_issuer #(.DEPTH(4), .WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op1(in_op1), .in_op2(in_op2), .in_operation(in_operation),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_operation(alu_operation),
    .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .count(count)
  );

  function automatic logic [15:0] alu_ref(input logic [15:0] a, input logic [15:0] b,
                                          input logic [1:0] op);
    case (op)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a ^ b;
      default: return a * b;
    endcase
  endfunction

  // sequential_alu stand-in: one registered cycle, reset tied to !rst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) alu_result <= '0;
    else      alu_result <= alu_ref(alu_op1, alu_op2, alu_operation);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cmd(input logic [15:0] a, input logic [15:0] b,
                         input logic [1:0] op, input logic [15:0] e);
    in_valid     = 1'b1;
    in_op1       = a;
    in_op2       = b;
    in_operation = op;
    cur_exp      = e;
  endtask

  // Called just after a falling edge; samples handshakes, then advances one cycle.
  task automatic tick();
    logic [15:0] e;
    #1;
    if (in_valid && in_ready) sb.push_back(cur_exp);
    if (out_valid && out_ready) begin
      total++;
      assert (sb.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_out observed=%0h expected=none", out_result);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("result", 32'(out_result), 32'(e));
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 40 && (sb.size() != 0 || out_valid); i++) tick();
    chk("drain_sb_empty", 32'(sb.size()), 32'd0);
    chk("drain_out_valid", 32'(out_valid), 32'd0);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_result"}, 32'(out_result), 32'd0);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_alu_op1"}, 32'(alu_op1), 32'd0);
    chk({tag, "_alu_op2"}, 32'(alu_op2), 32'd0);
    chk({tag, "_alu_operation"}, 32'(alu_operation), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  logic [15:0] s_a[5]  = '{16'd7, 16'hAAAA, 16'h00FF, 16'h0100, 16'd0};
  logic [15:0] s_b[5]  = '{16'd9, 16'h5555, 16'h0002, 16'h0100, 16'd1};
  logic [1:0]  s_op[5] = '{2'b00, 2'b10, 2'b11, 2'b11, 2'b01};
  logic [15:0] s_e[5]  = '{16'd16, 16'hFFFF, 16'h01FE, 16'h0000, 16'hFFFF};

  initial begin
    logic [15:0] bp_first;
    logic        accepted;
    rst = 1'b0; in_valid = 1'b0; in_op1 = '0; in_op2 = '0; in_operation = '0;
    out_ready = 1'b0; cur_exp = '0;

    // Reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid     = 1'($urandom_range(0, 1));
      out_ready    = 1'($urandom_range(0, 1));
      in_op1       = 16'($urandom);
      in_op2       = 16'($urandom);
      in_operation = 2'($urandom_range(0, 3));
      #1;
      chk_cleared("rst_hold");
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
    @(negedge clk);
    #1;
    chk_cleared("rst_release");

    // Single command latency
    out_ready = 1'b1;
    set_cmd(16'd3, 16'd5, 2'b00, 16'd8);
    tick();
    in_valid = 1'b0;
    #1;
    chk("lat_e0_valid", 32'(out_valid), 32'd0);
    chk("lat_e0_alu_op1", 32'(alu_op1), 32'd3);
    chk("lat_e0_alu_op2", 32'(alu_op2), 32'd5);
    chk("lat_e0_count", 32'(count), 32'd1);
    tick();
    chk("lat_e1_valid", 32'(out_valid), 32'd0);
    chk("lat_e1_alu_idle", 32'(alu_op1), 32'd0);
    chk("lat_e1_count", 32'(count), 32'd0);
    tick();
    chk("lat_e2_valid", 32'(out_valid), 32'd1);
    chk("lat_e2_result", 32'(out_result), 32'd8);
    tick();
    set_cmd(16'd3, 16'd5, 2'b01, 16'hFFFE);
    tick();
    drain();

    // Back-to-back streaming
    for (int i = 0; i < 5; i++) begin
      set_cmd(s_a[i], s_b[i], s_op[i], s_e[i]);
      tick();
      chk("stream_count", 32'(count), 32'd1);
      if (i >= 2) chk("stream_valid", 32'(out_valid), 32'd1);
    end
    drain();

    // Backpressure: 6 accepted, 7th held
    out_ready = 1'b0;
    bp_first  = alu_ref(16'd1, 16'd3, 2'b00);
    for (int i = 0; i < 6; i++) begin
      set_cmd(16'(i * 4099 + 1), 16'(i * 7 + 3), 2'(i),
              alu_ref(16'(i * 4099 + 1), 16'(i * 7 + 3), 2'(i)));
      chk("bp_in_ready", 32'(in_ready), 32'd1);
      tick();
    end
    set_cmd(16'd6 * 16'd4099 + 16'd1, 16'd45, 2'b10,
            alu_ref(16'd6 * 16'd4099 + 16'd1, 16'd45, 2'b10));
    chk("bp_full_count", 32'(count), 32'd4);
    chk("bp_full_in_ready", 32'(in_ready), 32'd0);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_hold_count", 32'(count), 32'd4);
      chk("bp_hold_result", 32'(out_result), 32'(bp_first));
      chk("bp_hold_alu_idle", 32'(alu_op1), 32'd0);
    end
    out_ready = 1'b1;
    accepted  = 1'b0;
    for (int k = 0; k < 10 && !accepted; k++) begin
      if (in_ready) accepted = 1'b1;
      tick();
    end
    chk("bp_7th_accepted", 32'(accepted), 32'd1);
    drain();

    // Push and issue in the same cycle at 2 entries
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_cmd(16'(100 + i), 16'(i), 2'b00, 16'(100 + 2 * i));
      tick();
    end
    chk("sim_count_before", 32'(count), 32'd2);
    out_ready = 1'b1;
    set_cmd(16'd200, 16'd1, 2'b00, 16'd201);
    #1;
    chk("sim_issue_head", 32'(alu_op1), 32'd102);
    tick();
    in_valid = 1'b0;
    chk("sim_count_after", 32'(count), 32'd2);
    drain();

    // Reset mid-stream: 3 in FIFO, 1 pending, 1 in result queue
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_cmd(16'(300 + i), 16'd1, 2'b00, 16'(301 + i));
      tick();
    end
    chk("mid_count_pre", 32'(count), 32'd3);
    out_ready = 1'b1;
    set_cmd(16'd400, 16'd0, 2'b00, 16'd400);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("mid_count", 32'(count), 32'd3);
    chk("mid_head", 32'(out_result), 32'd302);
    #2;
    rst = 1'b0;
    #1;
    chk_cleared("mid_rst");
    sb.delete();
    @(negedge clk);
    rst = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("post_rst_valid", 32'(out_valid), 32'd0);
    end
    set_cmd(16'd2, 16'd3, 2'b00, 16'd5);
    tick();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
